rf_write_ctrl: RTL and testbench
================================

# rf_write_ctrl

Write-port controller and scoreboard for the core's single-write-port register file. Shares the one write port between the in-order pipeline writeback (fixed priority, never stalled) and a multi-cycle execution unit (mul/div/load miss) whose results are buffered in a small FIFO. Tracks which architectural registers have an outstanding multi-cycle result, and raises a hazard to the decode stage when an instruction reads or overwrites one. Sits between writeback/multi-cycle unit and `reg_file`; its `rf_*` outputs drive the register file's `we`/`rd`/`wd` directly.

## Interface
- `XLEN`, 32, data width
- `ADDR_W`, 5, register address width (2^ADDR_W registers)
- `BUF_DEPTH`, 2, multi-cycle result FIFO depth (power of two, >=2)

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `pipe_we`  in  1  pipeline writeback write enable
- `pipe_rd`  in  ADDR_W  pipeline writeback destination
- `pipe_wd`  in  XLEN  pipeline writeback data
- `mc_valid`  in  1  multi-cycle unit presents a result
- `mc_ready`  out  1  result accepted this cycle when `mc_valid & mc_ready`
- `mc_rd`  in  ADDR_W  multi-cycle result destination
- `mc_wd`  in  XLEN  multi-cycle result data
- `issue_valid`  in  1  decode issues a multi-cycle op this cycle
- `issue_rd`  in  ADDR_W  destination of the issued op
- `dec_adr1`, `dec_adr2`, `dec_rd`  in  ADDR_W each  decode-stage source/destination addresses
- `hazard`  out  1  decode must stall
- `busy`  out  1  any pending bit set or FIFO non-empty
- `rf_we`  out  1  to `reg_file.we`
- `rf_rd`  out  ADDR_W  to `reg_file.rd`
- `rf_wd`  out  XLEN  to `reg_file.wd`

## Operation
- State: FIFO of {rd, data} (BUF_DEPTH entries, rd/wr pointers one bit wider than index), `pending[2^ADDR_W-1:0]` bit vector.
- Port select (combinational, each cycle): if `pipe_we & pipe_rd!=0` → port = pipeline (`rf_we=1`, `rf_rd=pipe_rd`, `rf_wd=pipe_wd`); else if FIFO non-empty → port = FIFO head (`rf_we=1`), head popped at the edge; else `rf_we=0`, `rf_rd=0`, `rf_wd=0`.
- Pipeline writes to x0 (`pipe_rd==0`) never take the port and never reach `rf_we`.
- `mc_ready = !full`. No bypass: accepted results always enqueue; full is computed before the same-cycle pop.
- Accepted result with `mc_rd==0`: consumed, not enqueued, no pending change.
- Pending set: `issue_valid & issue_rd!=0` sets `pending[issue_rd]`. Pending clear: FIFO head committed to the port clears `pending[head.rd]`. Same-cycle set and clear of the same index → set wins.
- `hazard = (dec_adr1!=0 & pending[dec_adr1]) | (dec_adr2!=0 & pending[dec_adr2]) | (dec_rd!=0 & pending[dec_rd])`. Covers RAW and WAW; decode never issues to a pending rd, so one bit per register suffices.
- Issuing to an already-pending rd is illegal; behaviour unspecified, flagged by a simulation assertion.
- A pipeline write to rd while `pending[rd]` is set is illegal (prevented by `hazard`); asserted in simulation.
- `busy = |pending | !empty`.

## Timing
- Reset (async assert, sync-safe deassert): FIFO empty, `pending=0`; hence `mc_ready=1`, `hazard=0`, `busy=0`, `rf_we=0`, `rf_rd=0`, `rf_wd=0` while `rst` high regardless of `pipe_we`.
- Reset mid-operation discards buffered results and all pending bits.
- Pipeline path: zero latency; `rf_*` valid the same cycle as `pipe_*`, register written on that edge.
- Multi-cycle path: result accepted at edge N is on `rf_*` earliest cycle N+1 (written at edge N+1); each cycle of pipeline priority delays it one cycle.
- `hazard` deasserts the cycle after the committing edge (pending cleared at that edge).
- FIFO full with pop and push offered same cycle: `mc_ready=0`, only the pop occurs.
- Pointer wrap: pointers wrap modulo 2*BUF_DEPTH; full = index equal & MSB differ.

## Test plan
- Reset: drive `pipe_we=1, pipe_rd=5`, `rst=1` → `rf_we=0`, `mc_ready=1`, `busy=0`; release, same inputs → `rf_we=1, rf_rd=5`.
- Issue rd=7, then `dec_adr1=7` → `hazard=1`; accept `mc_rd=7, mc_wd=0xDEADBEEF` with `pipe_we=0` → next cycle `rf_we=1, rf_rd=7, rf_wd=0xDEADBEEF`, cycle after `hazard=0`, `busy=0`.
- Priority: FIFO holds rd=3; `pipe_we=1, pipe_rd=4` for 3 cycles → rd=4 written 3 times, rd=3 written on 4th cycle, `pending[3]` set until then.
- Full/backpressure (BUF_DEPTH=2): 3 back-to-back `mc_valid` while `pipe_we=1` → first two accepted, `mc_ready=0` on third; drop `pipe_we` → drains in order, third accepted when not full.
- x0 handling: `pipe_rd=0, pipe_we=1` with FIFO non-empty → FIFO head written; `issue_rd=0` → no pending bit; `mc_rd=0` accepted, no write.
- Set/clear collision: head rd=9 committing while `issue_valid, issue_rd=9` → `pending[9]` remains 1, `hazard` for `dec_adr2=9` stays 1.

Source files
------------

// File: rtl/rf_write_ctrl.sv
// Register-file write-port arbiter: the pipeline writes with zero latency; buffered multi-cycle results fill idle port cycles.
// Multi-cycle results take one cycle or more from acceptance to write; mc_ready drops when the result FIFO is full.
module rf_write_ctrl #(
    parameter int XLEN      = 32,
    parameter int ADDR_W    = 5,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_rd,
    input  logic [XLEN-1:0]   pipe_wd,
    input  logic              mc_valid,
    output logic              mc_ready,
    input  logic [ADDR_W-1:0] mc_rd,
    input  logic [XLEN-1:0]   mc_wd,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] dec_adr1,
    input  logic [ADDR_W-1:0] dec_adr2,
    input  logic [ADDR_W-1:0] dec_rd,
    output logic              hazard,
    output logic              busy,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]   rf_wd
);
    localparam int IDX_W = $clog2(BUF_DEPTH);
    localparam int NREG  = 1 << ADDR_W;
    localparam int ENT_W = ADDR_W + XLEN;

    logic [ENT_W-1:0]  buf_mem [BUF_DEPTH];
    logic [IDX_W:0]    wr_ptr;
    logic [IDX_W:0]    rd_ptr;
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   pending_nxt;

    logic              empty;
    logic              full;
    logic              pipe_sel;
    logic              pop;
    logic              push;
    logic [ADDR_W-1:0] head_rd;
    logic [XLEN-1:0]   head_wd;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
    assign pipe_sel = pipe_we && (pipe_rd != '0);
    assign pop      = !rst && !pipe_sel && !empty;
    // Results for x0 are consumed without taking a FIFO slot.
    assign push     = mc_valid && !full && (mc_rd != '0);
    assign mc_ready = !full;
    assign {head_rd, head_wd} = buf_mem[rd_ptr[IDX_W-1:0]];

    always_comb begin
        rf_we = 1'b0;
        rf_rd = '0;
        rf_wd = '0;
        if (!rst) begin
            if (pipe_sel) begin
                rf_we = 1'b1;
                rf_rd = pipe_rd;
                rf_wd = pipe_wd;
            end else if (!empty) begin
                rf_we = 1'b1;
                rf_rd = head_rd;
                rf_wd = head_wd;
            end
        end
    end

    // Clear first so a same-cycle issue to the committing register keeps its bit.
    always_comb begin
        pending_nxt = pending;
        if (pop)
            pending_nxt[head_rd] = 1'b0;
        if (issue_valid && (issue_rd != '0))
            pending_nxt[issue_rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pending <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            pending <= pending_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            buf_mem[wr_ptr[IDX_W-1:0]] <= {mc_rd, mc_wd};
    end

    assign hazard = ((dec_adr1 != '0) && pending[dec_adr1])
                  | ((dec_adr2 != '0) && pending[dec_adr2])
                  | ((dec_rd   != '0) && pending[dec_rd]);
    assign busy   = (|pending) || !empty;

    a_issue_not_pending: assert property (@(posedge clk) disable iff (rst)
        !(issue_valid && (issue_rd != '0) && pending[issue_rd] && !(pop && (head_rd == issue_rd))));

    a_pipe_not_pending: assert property (@(posedge clk) disable iff (rst)
        !(pipe_sel && pending[pipe_rd]));
endmodule

// File: tb/tb_rf_write_ctrl.sv
// Scoreboarded bench for rf_write_ctrl: expected register writes are queued by the stimulus and matched by a write-port monitor.
module tb_rf_write_ctrl;
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wd;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wd;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_rd;
    logic [31:0] mc_wd;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  dec_adr1;
    logic [4:0]  dec_adr2;
    logic [4:0]  dec_rd;
    logic        hazard;
    logic        busy;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;

    int n_cmp;
    int n_bad;
    wr_t exp_q[$];

    rf_write_ctrl #(.XLEN(32), .ADDR_W(5), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_wd(mc_wd),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .dec_adr1(dec_adr1), .dec_adr2(dec_adr2), .dec_rd(dec_rd),
        .hazard(hazard), .busy(busy),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-port monitor: every write the DUT presents must match the next expected one.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got rd=%0d wd=%0h, required no write", rf_rd, rf_wd);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (rf_rd !== e.rd || rf_wd !== e.wd) begin
                    n_bad++;
                    $display("FAIL write_data: got rd=%0d wd=%0h, required rd=%0d wd=%0h",
                             rf_rd, rf_wd, e.rd, e.wd);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] wd);
        wr_t e;
        e.rd = rd;
        e.wd = wd;
        exp_q.push_back(e);
    endtask

    task automatic mid;
        @(negedge clk);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic we, input logic [4:0] rd, input logic [31:0] wd);
        pipe_we = we;
        pipe_rd = rd;
        pipe_wd = wd;
    endtask

    task automatic mc(input logic v, input logic [4:0] rd, input logic [31:0] wd);
        mc_valid = v;
        mc_rd    = rd;
        mc_wd    = wd;
    endtask

    task automatic issue(input logic v, input logic [4:0] rd);
        issue_valid = v;
        issue_rd    = rd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        pipe(1'b1, 5'd5, 32'h55);
        mc(1'b0, 5'd0, 32'h0);
        issue(1'b0, 5'd0);
        dec_adr1 = 5'd0;
        dec_adr2 = 5'd0;
        dec_rd   = 5'd0;

        // Reset holds the port idle even with a pipeline write offered
        mid;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_mc_ready", mc_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_hazard", hazard, 0);
        tick;
        rst = 1'b0;
        expect_wr(5'd5, 32'h55);
        mid;
        chk("pipe_rf_we", rf_we, 1);
        tick;

        // RAW hazard on an outstanding multi-cycle result
        pipe(1'b0, 5'd0, 32'h0);
        issue(1'b1, 5'd7);
        tick;
        issue(1'b0, 5'd0);
        dec_adr1 = 5'd7;
        mid;
        chk("raw_hazard", hazard, 1);
        chk("raw_busy", busy, 1);
        tick;
        mc(1'b1, 5'd7, 32'hDEADBEEF);
        mid;
        chk("raw_mc_ready", mc_ready, 1);
        chk("raw_no_write_yet", rf_we, 0);
        tick;
        mc(1'b0, 5'd0, 32'h0);
        expect_wr(5'd7, 32'hDEADBEEF);
        mid;
        chk("raw_hazard_commit_cycle", hazard, 1);
        tick;
        mid;
        chk("raw_hazard_clear", hazard, 0);
        chk("raw_busy_clear", busy, 0);
        dec_adr1 = 5'd0;
        tick;

        // Pipeline priority delays the buffered result
        issue(1'b1, 5'd3);
        mc(1'b1, 5'd3, 32'h33);
        tick;
        issue(1'b0, 5'd0);
        mc(1'b0, 5'd0, 32'h0);
        dec_rd = 5'd3;
        for (int i = 0; i < 3; i++) begin
            pipe(1'b1, 5'd4, 32'h40 + i);
            expect_wr(5'd4, 32'h40 + i);
            mid;
            chk("prio_hazard", hazard, 1);
            tick;
        end
        pipe(1'b0, 5'd0, 32'h0);
        expect_wr(5'd3, 32'h33);
        mid;
        chk("prio_hazard_commit", hazard, 1);
        tick;
        mid;
        chk("prio_hazard_clear", hazard, 0);
        dec_rd = 5'd0;
        tick;

        // Back-pressure with a two-entry buffer
        for (int i = 0; i < 3; i++) begin
            pipe(1'b1, 5'd4, 32'h50 + i);
            mc(1'b1, 5'd10 + i[4:0], 32'hA0 + i);
            expect_wr(5'd4, 32'h50 + i);
            mid;
            chk("full_mc_ready", mc_ready, (i < 2) ? 1 : 0);
            tick;
        end
        pipe(1'b0, 5'd0, 32'h0);
        expect_wr(5'd10, 32'hA0);
        mid;
        chk("full_pop_push_ready", mc_ready, 0);
        tick;
        expect_wr(5'd11, 32'hA1);
        mid;
        chk("drain_mc_ready", mc_ready, 1);
        tick;
        mc(1'b0, 5'd0, 32'h0);
        expect_wr(5'd12, 32'hA2);
        mid;
        chk("drain_busy", busy, 1);
        tick;
        mid;
        chk("drained_busy", busy, 0);
        chk("drained_rf_we", rf_we, 0);
        tick;

        // x0 handling
        mc(1'b1, 5'd13, 32'hD0);
        tick;
        mc(1'b0, 5'd0, 32'h0);
        pipe(1'b1, 5'd0, 32'hFF);
        issue(1'b1, 5'd0);
        expect_wr(5'd13, 32'hD0);
        mid;
        chk("x0_head_rf_rd", rf_rd, 13);
        tick;
        pipe(1'b0, 5'd0, 32'h0);
        issue(1'b0, 5'd0);
        mc(1'b1, 5'd0, 32'hEE);
        mid;
        chk("x0_issue_busy", busy, 0);
        chk("x0_mc_ready", mc_ready, 1);
        tick;
        mc(1'b0, 5'd0, 32'h0);
        mid;
        chk("x0_result_busy", busy, 0);
        tick;

        // Same-cycle set and clear of one pending bit
        issue(1'b1, 5'd9);
        mc(1'b1, 5'd9, 32'h99);
        tick;
        mc(1'b0, 5'd0, 32'h0);
        dec_adr2 = 5'd9;
        expect_wr(5'd9, 32'h99);
        mid;
        chk("coll_hazard_before", hazard, 1);
        tick;
        issue(1'b0, 5'd0);
        mid;
        chk("coll_hazard_kept", hazard, 1);
        chk("coll_busy", busy, 1);
        mc(1'b1, 5'd9, 32'h9A);
        tick;
        mc(1'b0, 5'd0, 32'h0);
        expect_wr(5'd9, 32'h9A);
        tick;
        mid;
        chk("coll_hazard_clear", hazard, 0);
        dec_adr2 = 5'd0;
        tick;

        // Reset mid-operation discards buffered results and pending bits
        issue(1'b1, 5'd20);
        mc(1'b1, 5'd20, 32'h20);
        tick;
        issue(1'b0, 5'd0);
        mc(1'b0, 5'd0, 32'h0);
        dec_adr1 = 5'd20;
        rst = 1'b1;
        mid;
        chk("midrst_busy", busy, 0);
        chk("midrst_hazard", hazard, 0);
        chk("midrst_rf_we", rf_we, 0);
        tick;
        rst = 1'b0;
        mid;
        chk("after_rst_busy", busy, 0);
        chk("after_rst_rf_we", rf_we, 0);
        tick;

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
